// File: rtl/game_step_scheduler.sv
// Frame-paced game-step scheduler with run/pause/halt control.
// Define SNAKE_SPEEDUP_EN to shorten the step interval as tail_count grows.
module game_step_scheduler #(
  parameter int H_LAST       = 639,
  parameter int V_LAST       = 479,
  parameter int BASE_FRAMES  = 8,
  parameter int MIN_FRAMES   = 2,
  parameter int SPEEDUP_STEP = 4,
  parameter int TAIL_W       = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        x_in,
  input  logic [9:0]        y_in,
  input  logic              start,
  input  logic              pause,
  input  logic              game_over,
  input  logic              game_won,
  input  logic [TAIL_W-1:0] tail_count,
  output logic              step,
  output logic              game_rst,
  output logic [1:0]        state,
  output logic [3:0]        frames_per_step
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_PAUSED = 2'd2;
  localparam logic [1:0] S_HALT   = 2'd3;

  logic       match;
  logic       match_q;
  logic       frame_end;
  logic       ended;
  logic [3:0] frame_cnt;
  logic [3:0] target;

  assign match     = (x_in == 10'(H_LAST)) && (y_in == 10'(V_LAST));
  assign frame_end = match & ~match_q;
  assign ended     = game_over | game_won;

`ifdef SNAKE_SPEEDUP_EN
  localparam int SHIFT = $clog2(SPEEDUP_STEP);
  logic [TAIL_W-1:0] tail_div;
  int                diff;

  assign tail_div = tail_count >> SHIFT;

  // Subtract in signed int so long tails saturate at the floor instead of wrapping.
  always_comb begin
    diff   = BASE_FRAMES - int'(tail_div);
    target = 4'(BASE_FRAMES);
    if (diff < MIN_FRAMES) target = 4'(MIN_FRAMES);
    else                   target = 4'(diff);
  end
`else
  logic unused_tail;
  assign unused_tail = ^tail_count;
  assign target      = 4'(BASE_FRAMES);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      step            <= 1'b0;
      game_rst        <= 1'b0;
      frames_per_step <= 4'(BASE_FRAMES);
      frame_cnt       <= '0;
      match_q         <= 1'b0;
    end else begin
      match_q  <= match;
      step     <= 1'b0;
      game_rst <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state           <= S_RUN;
            frame_cnt       <= '0;
            frames_per_step <= target;
          end
        end
        S_RUN: begin
          if (ended) begin
            state     <= S_HALT;
            frame_cnt <= '0;
          end else if (pause) begin
            state <= S_PAUSED;
          end else if (frame_end) begin
            if (frame_cnt == frames_per_step - 4'd1) begin
              frame_cnt       <= '0;
              step            <= 1'b1;
              frames_per_step <= target;
            end else begin
              frame_cnt <= frame_cnt + 4'd1;
            end
          end
        end
        S_PAUSED: begin
          if (ended) begin
            state     <= S_HALT;
            frame_cnt <= '0;
          end else if (pause) begin
            state <= S_RUN;
          end
        end
        default: begin
          if (start) begin
            state    <= S_IDLE;
            game_rst <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_step_scheduler.sv
// Randomized + directed bench for game_step_scheduler against a frame-level reference model.
module tb_game_step_scheduler;

  localparam int BASE = 3;
  localparam int MINF = 1;
  localparam int SPD  = 2;
`ifdef SNAKE_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] x_in = '0;
  logic [9:0] y_in = '0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       game_over = 1'b0;
  logic       game_won = 1'b0;
  logic [5:0] tail_count = '0;
  logic       step;
  logic       game_rst;
  logic [1:0] state;
  logic [3:0] frames_per_step;

  game_step_scheduler #(
    .H_LAST(639), .V_LAST(479), .BASE_FRAMES(BASE), .MIN_FRAMES(MINF),
    .SPEEDUP_STEP(SPD), .TAIL_W(6)
  ) dut (
    .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in), .start(start),
    .pause(pause), .game_over(game_over), .game_won(game_won),
    .tail_count(tail_count), .step(step), .game_rst(game_rst),
    .state(state), .frames_per_step(frames_per_step)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int steps_seen = 0;

  // Reference model: 0 idle, 1 run, 2 paused, 3 halt
  int m_state, m_frames, m_fps;
  bit m_step, m_grst, m_prev;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int target_of(input int tail);
    int t;
    if (!SPEEDUP) return BASE;
    t = BASE - tail / SPD;
    return (t < MINF) ? MINF : t;
  endfunction

  task automatic model_clock();
    bit fe, hit;
    hit = (x_in == 10'd639) && (y_in == 10'd479);
    if (reset) begin
      m_state = 0; m_frames = 0; m_fps = BASE;
      m_step = 0; m_grst = 0; m_prev = 0;
      return;
    end
    fe = hit && !m_prev;
    m_prev = hit;
    m_step = 0;
    m_grst = 0;
    case (m_state)
      0: if (start) begin m_state = 1; m_frames = 0; m_fps = target_of(int'(tail_count)); end
      1: begin
        if (game_over || game_won) begin m_state = 3; m_frames = 0; end
        else if (pause) m_state = 2;
        else if (fe) begin
          m_frames++;
          if (m_frames >= m_fps) begin
            m_frames = 0; m_step = 1; m_fps = target_of(int'(tail_count));
          end
        end
      end
      2: begin
        if (game_over || game_won) begin m_state = 3; m_frames = 0; end
        else if (pause) m_state = 1;
      end
      default: if (start) begin m_state = 0; m_grst = 1; end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
    if (step) steps_seen++;
    check_val("state", int'(state), m_state);
    check_val("step", int'(step), int'(m_step));
    check_val("game_rst", int'(game_rst), int'(m_grst));
    check_val("fps", int'(frames_per_step), m_fps);
  endtask

  task automatic idle_coord();
    x_in = 10'($urandom_range(0, 639));
    y_in = 10'($urandom_range(0, 478));
  endtask

  task automatic frame(input int hold);
    x_in = 10'd639; y_in = 10'd479;
    repeat (hold) tick();
    idle_coord();
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0; tick();
  endtask

  task automatic pulse_pause();
    pause = 1'b1; tick(); pause = 1'b0; tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; idle_coord();
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s0;
    // reset state
    do_reset();
    check_val("rst_state", int'(state), 0);
    check_val("rst_fps", int'(frames_per_step), BASE);
    check_val("rst_step", int'(step), 0);

    // seven frame ends -> steps after 3rd and 6th
    pulse_start();
    check_val("run_after_start", int'(state), 1);
    s0 = steps_seen;
    repeat (7) frame(1);
    check_val("steps_7_frames", steps_seen - s0, 2);

    // held coordinates count once per frame
    do_reset(); pulse_start();
    s0 = steps_seen;
    repeat (6) begin frame(5); idle_coord(); tick(); end
    check_val("steps_held_frames", steps_seen - s0, 2);

    // tail-driven speed-up applies only after the next step
    do_reset(); tail_count = 6'd0; pulse_start();
    tail_count = 6'd2;
    tick();
    check_val("fps_not_shortened", int'(frames_per_step), 3);
    repeat (3) frame(1);
    check_val("fps_tail2", int'(frames_per_step), SPEEDUP ? 2 : 3);
    tail_count = 6'd4;
    repeat (SPEEDUP ? 2 : 3) frame(1);
    check_val("fps_tail4", int'(frames_per_step), SPEEDUP ? 1 : 3);
    tail_count = 6'd10;
    repeat (SPEEDUP ? 1 : 3) frame(1);
    check_val("fps_tail10_sat", int'(frames_per_step), SPEEDUP ? 1 : 3);
    tail_count = 6'd0;

    // pause holds the counter
    do_reset(); pulse_start();
    repeat (2) frame(1);
    pulse_pause();
    check_val("paused", int'(state), 2);
    s0 = steps_seen;
    repeat (4) frame(1);
    check_val("no_step_paused", steps_seen - s0, 0);
    pulse_pause();
    check_val("resumed", int'(state), 1);
    frame(1);
    check_val("step_after_resume", steps_seen - s0, 1);

    // game_over coincident with completing frame end
    do_reset(); pulse_start();
    repeat (2) frame(1);
    s0 = steps_seen;
    x_in = 10'd639; y_in = 10'd479; game_over = 1'b1;
    tick();
    idle_coord(); tick();
    check_val("halt_on_over", int'(state), 3);
    check_val("no_step_on_over", steps_seen - s0, 0);
    game_over = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    check_val("grst_pulse", int'(game_rst), 1);
    check_val("idle_after_halt", int'(state), 0);
    tick();
    check_val("grst_one_cycle", int'(game_rst), 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin x_in = 10'd639; y_in = 10'd479; end
      else idle_coord();
      start = ($urandom_range(0, 39) == 0);
      pause = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 79) == 0) game_over = ~game_over;
      if ($urandom_range(0, 119) == 0) game_won = ~game_won;
      if ($urandom_range(0, 99) == 0) tail_count = 6'($urandom_range(0, 63));
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/game_step_scheduler.md
# game_step_scheduler

Sequences snake game-state updates against the VGA scan. Counts completed frames from the pixel coordinates and issues a one-cycle `step` strobe every `frames_per_step` frames. Runs a run/pause/halt state machine driven by buttons and game status. Sits between the VGA coordinate generator and the game-logic core, replacing its free-running update-rate derivation with an explicit, pausable, speed-scaled scheduler.

## Interface
Parameters:
- `H_LAST`, 639: last visible pixel column.
- `V_LAST`, 479: last visible pixel row.
- `BASE_FRAMES`, 8: frames per step with zero tails; range 1..15.
- `MIN_FRAMES`, 2: floor for frames per step; 1..`BASE_FRAMES`.
- `SPEEDUP_STEP`, 4: tails per one-frame speed-up; power of two, ≥1.
- `TAIL_W`, 6: width of `tail_count`.

Ports:
- `clk` in 1: system/pixel clock.
- `reset` in 1: synchronous, active-high.
- `x_in` in 10: current pixel column.
- `y_in` in 10: current pixel row.
- `start` in 1: debounced one-cycle start/restart pulse.
- `pause` in 1: debounced one-cycle pause-toggle pulse.
- `game_over` in 1: level, from game logic.
- `game_won` in 1: level, from game logic.
- `tail_count` in `TAIL_W`: current tail length.
- `step` out 1: one-cycle update strobe to game logic.
- `game_rst` out 1: one-cycle request to re-initialise game logic.
- `state` out 2: 0 IDLE, 1 RUN, 2 PAUSED, 3 HALT.
- `frames_per_step` out 4: interval currently in force.

## Operation
- Frame-end detect: `match = (x_in==H_LAST && y_in==V_LAST)`; `match_q` registered. `frame_end = match & ~match_q`, so coordinates held for several cycles count as one frame.
- Frame counter, 4 bits:
  - Increments on `frame_end` only in RUN.
  - When `frame_end` arrives with counter == `frames_per_step`-1, the counter clears, `step` pulses, and `frames_per_step` reloads from the computed target.
- Target computation: `BASE_FRAMES - (tail_count / SPEEDUP_STEP)`, using a shift and a signed-safe subtract, saturated to `MIN_FRAMES`. Underflow must saturate, never wrap.
- `frames_per_step` is latched only on a step, on entering RUN from IDLE, and on reset, so `tail_count` changes mid-interval never shorten the interval being counted.
- State transitions:
  - IDLE: `start` → RUN; counter cleared; target latched.
  - RUN: `game_over|game_won` → HALT, with priority over everything else. Otherwise `pause` → PAUSED.
  - PAUSED: `game_over|game_won` → HALT. Otherwise `pause` → RUN. Counter is held, not cleared.
  - HALT: `start` → IDLE with `game_rst` pulse. Counter cleared on HALT entry.
- Ignored inputs:
  - `start` in RUN/PAUSED.
  - `pause` in IDLE/HALT.
- Simultaneous events:
  - `start` and `pause` in IDLE: start wins, pause ignored.
  - Interval completion with `game_over|game_won`: go to HALT, no `step`.
  - Interval completion with `pause`: go to PAUSED, no `step`, counter held at its pre-increment value.
- `step` is never asserted outside RUN.

## Timing
- Reset values: `state`=0, `step`=0, `game_rst`=0, `frames_per_step`=`BASE_FRAMES`, counter=0, `match_q`=0.
- Reset mid-operation discards the pending interval; no `step` on the cycle after reset.
- `step` is registered. It asserts in cycle t+1 when the completing `frame_end` is seen in cycle t, for exactly one cycle.
- `game_rst` is registered. It asserts the cycle after `start` is sampled in HALT, for one cycle. `state` reads IDLE in that same cycle.
- State updates one cycle after the causing input is sampled.
- `frames_per_step` reload is visible in the same cycle `step` asserts.
- Minimum spacing between `step` pulses is `MIN_FRAMES` frames.

## Configuration
- `SNAKE_SPEEDUP_EN` defined: target computed from `tail_count` as above.
- Not defined: target is the constant `BASE_FRAMES`; `tail_count` is unused, and `frames_per_step` is constant after reset.
- State machine and timing are identical in both builds.

## Test plan
Use `BASE_FRAMES`=3, `MIN_FRAMES`=1, `SPEEDUP_STEP`=2, with `SNAKE_SPEEDUP_EN` defined unless noted.
- Reset, `start`, 7 frame ends, `tail_count`=0 → `step` after frame ends 3 and 6 only; each `step` lasts 1 cycle, 1 cycle after the detecting cycle.
- Hold `x_in`=639 and `y_in`=479 for 5 cycles per frame → each held frame counts once; `step` still every 3 frames.
- `tail_count`=2, then 4, then 10, with a step between each change → `frames_per_step` goes 3→2→1→1 (saturated); the new value applies only after the next `step`.
- `pause` after 2 frames in RUN, 4 frame ends while PAUSED, `pause`, then 1 frame end → no `step` while paused; `step` after the first frame end following resume.
- `game_over` in the same cycle as the 3rd frame end → state HALT, no `step`. Then `start` → `game_rst` for 1 cycle and state IDLE.
- Compile without `SNAKE_SPEEDUP_EN`, `tail_count`=10 → `frames_per_step` stays 3 and `step` comes every 3 frames.
